param_register_bank: RTL
========================

Name: param_register_bank

Overview:
- Parametrised successor to the fixed 32x16 test-mode register bank: NREG configuration registers of DATA_W bits, a one-bit control register, and one read-only status word.
- Adds explicit write/read strobes, a registered read port with valid/error flags, a two-key unlock state machine guarding configuration writes, and write-error reporting.
- Sits between the slow-control command decoder and the front-end configuration logic; `regs_flat` fans out to downstream blocks.

Parameters:
- DATA_W, 16: width of every configuration register, the status word and the data buses.
- ADDR_W, 16: width of the `waddr`/`raddr` buses.
- NREG, 32: number of configuration registers, mapped at addresses 1..NREG (legal range 1..254).
- RST_VAL, 0: reset value loaded into every configuration register.
- KEY_ADDR, 16'h00FF: address of the unlock/lock key register (write-only).
- CTRL_ADDR, 16'h0100: address of the one-bit control register.
- STATUS_ADDR, 16'h0101: address of the read-only status word.
- KEY1, 16'hA5A5: first unlock key.
- KEY2, 16'h5A5A: second unlock key.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- test_mode  in  1  configuration writes are allowed only while this is 1.
- wr_en  in  1  write strobe, one transfer per cycle.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- raddr  in  ADDR_W  read address.
- status_in  in  DATA_W  live status, sampled on a read of STATUS_ADDR.
- rdata  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse marking rdata valid.
- rd_err  out  1  pulse with rd_valid when the read address is unmapped.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- unlocked  out  1  high while the lock FSM is in UNLOCKED.
- regs_flat  out  NREG*DATA_W  configuration registers; register k occupies bits [k*DATA_W-1 : (k-1)*DATA_W].
- ctrl_bit  out  1  control bit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - every register = RST_VAL; ctrl_bit = 0;
  - rdata = 0; rd_valid, rd_err, wr_err = 0;
  - lock FSM = LOCKED, so unlocked = 0.
- Lock FSM states: LOCKED, HALF, UNLOCKED. Only writes to KEY_ADDR, plus the abort rule below, change the state.
  - LOCKED: write KEY_ADDR with wdata==KEY1 -> HALF. Any other value -> stay LOCKED, wr_err pulses.
  - HALF: the very next wr_en cycle decides.
    - KEY_ADDR with wdata==KEY2 -> UNLOCKED.
    - Anything else (wrong key, or any other address) -> LOCKED with a wr_err pulse; that write is discarded.
    - Idle cycles with no wr_en keep the state at HALF.
  - UNLOCKED: any write to KEY_ADDR -> LOCKED, with no error.
  - test_mode falling to 0 forces LOCKED on the next edge from any state.
- Configuration write (waddr in 1..NREG): the register updates at the edge when wr_en=1, test_mode=1 and the state is UNLOCKED. Otherwise the register is unchanged and wr_err pulses on the next cycle.
- CTRL_ADDR write: ctrl_bit <= wdata[0]. This requires wr_en only; it is independent of test_mode and the lock state.
- Rejected writes, each giving a wr_err pulse on the next cycle with no state change:
  - writes to STATUS_ADDR;
  - writes to address 0;
  - writes to any other unmapped address.
- Read latency: rd_en sampled at edge N gives rdata, rd_valid=1 and rd_err after edge N+1.
  - rdata holds its last value when no read is issued.
  - rd_valid and rd_err stay high for one cycle only.
- Read map:
  - 1..NREG -> register value;
  - CTRL_ADDR -> zero-extended ctrl_bit;
  - STATUS_ADDR -> status_in sampled at edge N;
  - KEY_ADDR -> {DATA_W-2 zeros, state==HALF, unlocked};
  - all other addresses -> rdata=0 with rd_err=1.
- Read and write to the same address in the same cycle: the read returns the pre-write value (read-before-write).
- Back-to-back reads: one result per cycle, fully pipelined.
- Reset asserted mid-transaction: any pending rd_valid or wr_err pulse is dropped, and the outputs take their reset values immediately.

Optional Feature:
- Macro: REG_BANK_SHADOW_EN.
- When defined:
  - configuration writes land in a shadow array;
  - regs_flat drives from the live array;
  - a write to address NREG+1 with wdata[0]=1 copies shadow to live in one edge (commit; legal only when UNLOCKED, otherwise wr_err);
  - reads of 1..NREG return the shadow contents;
  - reset clears both arrays to RST_VAL.
- When not defined: no shadow array; writes update regs_flat directly; address NREG+1 is unmapped.

Test Plan:
- Locked write:
  - stimulus: reset, test_mode=1, write reg 3 = 0x1234, then read reg 3;
  - required: wr_err pulse, rdata=0x0000 (RST_VAL), rd_valid one cycle after rd_en.
- Unlock then write:
  - stimulus: write KEY_ADDR=0xA5A5, then KEY_ADDR=0x5A5A, then reg 32 = 0xBEEF, then read 32;
  - required: unlocked=1 after the second key, rdata=0xBEEF, regs_flat[511:496]=0xBEEF.
- Aborted key sequence:
  - stimulus: 0xA5A5 to KEY_ADDR, then write reg 1 = 0x0001;
  - required: wr_err pulse, state LOCKED, reg 1 unchanged.
- Unmapped and status accesses:
  - stimulus: read 0x0000, then read 0x0200, then read STATUS_ADDR with status_in=0x00C3;
  - required: rd_err=1 with rdata=0 for the first two reads; rdata=0x00C3 with rd_err=0 for the third.
- Same-cycle read and write:
  - stimulus: with the bank unlocked and reg 5=0x0011, write reg 5 = 0x0022 and read reg 5 in the same cycle, then read again;
  - required: first read 0x0011, second read 0x0022.
- Control bit and forced relock:
  - stimulus: test_mode=0, write CTRL_ADDR=0x0001; then, while UNLOCKED, drop test_mode;
  - required: ctrl_bit=1; unlocked=0 on the next edge.

Source files
------------

// File: rtl/param_register_bank.sv
// Parametrised configuration register bank with a two-key write unlock, registered read port
// and error pulses. Define REG_BANK_SHADOW_EN to stage writes in a shadow array with a commit.
module param_register_bank #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                NREG        = 32,
  parameter logic [DATA_W-1:0] RST_VAL     = 16'h0000,
  parameter logic [ADDR_W-1:0] KEY_ADDR    = 16'h00FF,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = 16'h0100,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 16'h0101,
  parameter logic [DATA_W-1:0] KEY1        = 16'hA5A5,
  parameter logic [DATA_W-1:0] KEY2        = 16'h5A5A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   test_mode,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      raddr,
  input  logic [DATA_W-1:0]      status_in,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rd_valid,
  output logic                   rd_err,
  output logic                   wr_err,
  output logic                   unlocked,
  output logic [NREG*DATA_W-1:0] regs_flat,
  output logic                   ctrl_bit
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [ADDR_W-1:0] LAST_CFG = ADDR_W'(NREG);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    HALF     = 2'd1,
    UNLOCKED = 2'd2
  } lock_state_t;

  lock_state_t       state;
  logic              cfg_hit, key_hit, ctrl_hit, commit_hit;
  logic              cfg_we, ctrl_we, wr_reject;
  logic [IDX_W-1:0]  widx, ridx;
  logic [DATA_W-1:0] rd_mux;
  logic              rd_unmapped;
  logic [DATA_W-1:0] cfg_q [NREG];

`ifdef REG_BANK_SHADOW_EN
  localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(NREG + 1);
  logic [DATA_W-1:0] live_q [NREG];
  logic              commit_we;

  assign commit_hit = (waddr == COMMIT_ADDR);
  assign commit_we  = wr_en && commit_hit && wdata[0] && test_mode && (state == UNLOCKED);

  // Commit copies the whole shadow image into the live array in a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) live_q[i] <= RST_VAL;
    end else if (commit_we) begin
      for (int i = 0; i < NREG; i++) live_q[i] <= cfg_q[i];
    end else begin
      for (int i = 0; i < NREG; i++) live_q[i] <= live_q[i];
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = live_q[k];
  end
`else
  assign commit_hit = 1'b0;

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = cfg_q[k];
  end
`endif

  // Write-side address decode and accept/reject decision for the current transfer.
  always_comb begin
    cfg_hit  = (waddr != '0) && (waddr <= LAST_CFG);
    key_hit  = (waddr == KEY_ADDR);
    ctrl_hit = (waddr == CTRL_ADDR);
    widx     = IDX_W'(waddr - ADDR_W'(1));
    cfg_we   = wr_en && cfg_hit && test_mode && (state == UNLOCKED);
    // A pending half-unlock swallows whatever write comes next, control writes included.
    ctrl_we  = wr_en && ctrl_hit && (state != HALF);
    wr_reject = 1'b0;
    if (wr_en) begin
      case (state)
        LOCKED: begin
          if (key_hit) wr_reject = !(test_mode && (wdata == KEY1));
          else         wr_reject = !ctrl_hit;
        end
        HALF:     wr_reject = !(test_mode && key_hit && (wdata == KEY2));
        UNLOCKED: begin
          if (key_hit || ctrl_hit)        wr_reject = 1'b0;
          else if (cfg_hit || commit_hit) wr_reject = !test_mode;
          else                            wr_reject = 1'b1;
        end
        default:  wr_reject = 1'b1;
      endcase
    end else begin
      wr_reject = 1'b0;
    end
  end

  // Read-side address map; the value is captured into rdata on the sampling edge.
  always_comb begin
    ridx        = IDX_W'(raddr - ADDR_W'(1));
    rd_mux      = '0;
    rd_unmapped = 1'b0;
    if ((raddr != '0) && (raddr <= LAST_CFG)) begin
      rd_mux = cfg_q[ridx];
    end else if (raddr == CTRL_ADDR) begin
      rd_mux = {{(DATA_W-1){1'b0}}, ctrl_bit};
    end else if (raddr == STATUS_ADDR) begin
      rd_mux = status_in;
    end else if (raddr == KEY_ADDR) begin
      rd_mux = {{(DATA_W-2){1'b0}}, (state == HALF), unlocked};
    end else begin
      rd_mux      = '0;
      rd_unmapped = 1'b1;
    end
  end

  // Lock state machine; unlocked is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOCKED;
      unlocked <= 1'b0;
    end else if (!test_mode) begin
      state    <= LOCKED;
      unlocked <= 1'b0;
    end else if (wr_en) begin
      case (state)
        LOCKED: begin
          if (key_hit && (wdata == KEY1)) state <= HALF;
          else                            state <= LOCKED;
          unlocked <= 1'b0;
        end
        HALF: begin
          if (key_hit && (wdata == KEY2)) begin
            state    <= UNLOCKED;
            unlocked <= 1'b1;
          end else begin
            state    <= LOCKED;
            unlocked <= 1'b0;
          end
        end
        UNLOCKED: begin
          if (key_hit) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
          end else begin
            state    <= UNLOCKED;
            unlocked <= 1'b1;
          end
        end
        default: begin
          state    <= LOCKED;
          unlocked <= 1'b0;
        end
      endcase
    end else begin
      state    <= state;
      unlocked <= unlocked;
    end
  end

  // Configuration array (the shadow copy when staging is enabled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cfg_q[i] <= RST_VAL;
    end else if (cfg_we) begin
      cfg_q[widx] <= wdata;
    end else begin
      cfg_q[widx] <= cfg_q[widx];
    end
  end

  // Control bit and write-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_bit <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      ctrl_bit <= ctrl_we ? wdata[0] : ctrl_bit;
      wr_err   <= wr_reject;
    end
  end

  // Registered read port: one result per cycle, rdata held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && rd_unmapped;
      rdata    <= rd_en ? rd_mux : rdata;
    end
  end

endmodule
